// File: rtl/prio_arbiter.sv
// -----------------------------------------------------------------------------
// prio_arbiter
//   Registered priority encoder / arbiter. Selects one active request from a
//   WIDTH-bit vector, using either fixed priority (highest index wins) or
//   round-robin priority (scan upward from the last transferred grant). The
//   winner is held in an output register and released via valid/ready.
//
// Parameters
//   WIDTH        number of request lines (2..32)
//   IDXW         derived index width, $clog2(WIDTH); not overridable
//
// Ports
//   clk          clock, all state on rising edge
//   rst_n        asynchronous active-low reset
//   ena          capture enable; 0 blocks new captures
//   req          request vector, bit i = requester i
//   mode         0 = fixed priority, 1 = round-robin (sampled at capture)
//   out_ready    consumer accepts the current grant
//   out_valid    grant register holds an unconsumed grant
//   out_idx      index of the granted requester
//   out_onehot   one-hot of out_idx; zero when out_valid = 0
//   grant_count  completed-transfer counter (16 bit, wrapping)
//
// Build option
//   PRIO_ARB_STATS_EN  when defined, grant_count counts completed transfers;
//                      otherwise grant_count is tied to zero.
// -----------------------------------------------------------------------------
module prio_arbiter #(
    parameter  int WIDTH = 16,
    localparam int IDXW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] req,
    input  logic             mode,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDXW-1:0]  out_idx,
    output logic [WIDTH-1:0] out_onehot,
    output logic [15:0]      grant_count
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDXW-1:0]   last;
    logic              capture;
    logic              xfer;
    logic [IDXW-1:0]   fix_idx;
    logic [IDXW-1:0]   rr_idx;
    logic [IDXW-1:0]   rr_base;
    logic              rr_found;
    logic [IDXW-1:0]   cand;
    logic [IDXW-1:0]   win_idx;

    function automatic logic [IDXW-1:0] wrap_idx(input int unsigned p);
        return IDXW'(p % WIDTH);
    endfunction

    assign xfer    = (state == HOLD) && out_ready;
    assign capture = ena && (|req) && ((state == IDLE) || out_ready);

    // Fixed priority: the last set bit seen in an ascending scan is the highest.
    always_comb begin
        fix_idx = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (req[i]) fix_idx = IDXW'(i);
        end
    end

    // A capture in HOLD always coincides with the transfer of out_idx, so the
    // scan must start after out_idx rather than the not-yet-updated last.
    always_comb begin
        rr_base  = (state == HOLD) ? out_idx : last;
        rr_idx   = '0;
        rr_found = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= WIDTH; k++) begin
            cand = wrap_idx(32'(rr_base) + k);
            if (!rr_found && req[cand]) begin
                rr_idx   = cand;
                rr_found = 1'b1;
            end
        end
    end

    assign win_idx = mode ? rr_idx : fix_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (capture) state_nxt = HOLD;
            HOLD:    if (capture)   state_nxt = HOLD;
                     else if (xfer) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign out_valid = (state == HOLD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_idx    <= '0;
            out_onehot <= '0;
            last       <= IDXW'(WIDTH - 1);
        end else begin
            if (capture) begin
                out_idx    <= win_idx;
                out_onehot <= WIDTH'(1) << win_idx;
            end else if (xfer) begin
                out_onehot <= '0;
            end
            if (xfer) last <= out_idx;
        end
    end

`ifdef PRIO_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    grant_count <= '0;
        else if (xfer) grant_count <= grant_count + 16'd1;
    end
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_prio_arbiter.sv
module tb_prio_arbiter;

    localparam int WIDTH = 16;
`ifdef PRIO_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [15:0] req;
    logic        mode;
    logic        out_ready;
    logic        out_valid;
    logic [3:0]  out_idx;
    logic [15:0] out_onehot;
    logic [15:0] grant_count;

    prio_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ena         (ena),
        .req         (req),
        .mode        (mode),
        .out_ready   (out_ready),
        .out_valid   (out_valid),
        .out_idx     (out_idx),
        .out_onehot  (out_onehot),
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  idx;
        logic [15:0] oh;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   xfers = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int idx);
        exp_t e;
        e.idx = 4'(idx);
        e.oh  = 16'(1) << idx;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        xfers = 0;
        q.delete();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [15:0] exp_count(input int n);
        return STATS ? 16'(n) : 16'h0000;
    endfunction

    // Monitor: every handshake seen before an edge is a transfer on that edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_grant", {28'h0, out_idx}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("grant", {12'h0, out_idx, out_onehot}, {12'h0, e.idx, e.oh});
                end
                xfers++;
            end else if (!out_valid) begin
                if (out_onehot !== 16'h0) check("onehot_idle", {16'h0, out_onehot}, 32'h0);
            end
        end
    end

    initial begin
        ena = 0; req = '0; mode = 0; out_ready = 0; rst_n = 0;

        // Reset state
        do_reset();
        check("rst_valid", {31'h0, out_valid}, 0);
        check("rst_idx", {28'h0, out_idx}, 0);
        check("rst_onehot", {16'h0, out_onehot}, 0);
        check("rst_count", {16'h0, grant_count}, 0);

        // Fixed priority, back-to-back
        mode = 0; req = 16'h0012; ena = 1; out_ready = 1;
        for (int i = 0; i < 4; i++) push_exp(4);
        tick();
        check("fix_valid", {31'h0, out_valid}, 1);
        check("fix_idx", {28'h0, out_idx}, 4);
        check("fix_onehot", {16'h0, out_onehot}, 32'h0010);
        for (int i = 0; i < 3; i++) tick();
        ena = 0;
        tick();
        check("fix_drain_valid", {31'h0, out_valid}, 0);
        check("fix_drain_onehot", {16'h0, out_onehot}, 0);

        // Asynchronous reset while holding a grant
        mode = 0; req = 16'h0010; ena = 1; out_ready = 0;
        tick();
        check("hold_valid", {31'h0, out_valid}, 1);
        check("hold_idx", {28'h0, out_idx}, 4);
        ena = 0;
        #2;
        rst_n = 0;
        xfers = 0;
        #1;
        check("async_rst_valid", {31'h0, out_valid}, 0);
        check("async_rst_idx", {28'h0, out_idx}, 0);
        check("async_rst_onehot", {16'h0, out_onehot}, 0);
        tick();
        rst_n = 1;

        // Round-robin from reset
        mode = 1; req = 16'h8421; ena = 1; out_ready = 1;
        push_exp(0); push_exp(5); push_exp(10); push_exp(15); push_exp(0); push_exp(5);
        tick();
        check("rr_first_idx", {28'h0, out_idx}, 0);
        for (int i = 0; i < 5; i++) tick();
        ena = 0;
        tick();
        check("rr_drain_valid", {31'h0, out_valid}, 0);

        // Backpressure with req and mode changing during HOLD
        mode = 0; req = 16'h0010; ena = 1; out_ready = 0;
        push_exp(4);
        tick();
        req = 16'h0001; mode = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_idx", {28'h0, out_idx}, 4);
            check("bp_valid", {31'h0, out_valid}, 1);
        end
        mode = 0; out_ready = 1;
        push_exp(0);
        tick();
        check("bp_release_idx", {28'h0, out_idx}, 0);
        ena = 0;
        tick();
        check("bp_drain_valid", {31'h0, out_valid}, 0);

        // Enable low and empty request vector
        ena = 0; req = 16'hFFFF; out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("ena0_valid", {31'h0, out_valid}, 0);
        end
        ena = 1; req = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("empty_valid", {31'h0, out_valid}, 0);
        end
        check("count_8", {16'h0, grant_count}, {16'h0, exp_count(xfers)});
        check("xfers_8", xfers, 8);

        // Five transfers after reset
        ena = 0;
        do_reset();
        mode = 0; req = 16'h0002; ena = 1; out_ready = 1;
        for (int i = 0; i < 5; i++) push_exp(1);
        for (int i = 0; i < 5; i++) tick();
        ena = 0;
        tick();
        check("count_5", {16'h0, grant_count}, {16'h0, exp_count(5)});

`ifdef PRIO_ARB_STATS_EN
        // Counter wrap: 65537 transfers leave 1
        do_reset();
        mode = 0; req = 16'h0002; ena = 1; out_ready = 1;
        for (int i = 0; i < 65537; i++) push_exp(1);
        for (int i = 0; i < 65537; i++) tick();
        ena = 0;
        tick();
        check("count_wrap", {16'h0, grant_count}, 1);
`endif

        check("scoreboard_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
